// File: rtl/mack_bus_master.sv
// Mackerel 68000-style bus initiator.
// Turns a req/done handshake into an AS/UDS/LDS bus cycle with DTACK timeout.
module mack_bus_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        busy,
  output logic        done,
  output logic        berr,
  output logic [15:0] rdata,
  output logic [22:0] addr,
  output logic [15:0] d_out,
  output logic        d_oe,
  input  logic [15:0] d_in,
  output logic        as,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  input  logic        dtack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STRB,
    S_WAIT,
    S_SAMPLE,
    S_RELEASE
  } state_t;

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        l_rw;
  logic [1:0]  l_be;
  logic        err;
  logic [15:0] cnt;
  logic        dtack_m;
  logic        dtack_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      l_rw    <= 1'b1;
      l_be    <= 2'b11;
      err     <= 1'b0;
      cnt     <= '0;
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      berr    <= 1'b0;
      rdata   <= '0;
      addr    <= '0;
      d_out   <= '0;
      d_oe    <= 1'b0;
      as      <= 1'b1;
      uds     <= 1'b1;
      lds     <= 1'b1;
      rw      <= 1'b1;
    end else begin
      dtack_m <= dtack;
      dtack_s <= dtack_m;
      done    <= 1'b0;
      berr    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            l_rw  <= req_rw;
            l_be  <= (req_be == 2'b00) ? 2'b11 : req_be;
            err   <= 1'b0;
            addr  <= req_addr;
            rw    <= req_rw;
            d_oe  <= ~req_rw;
            busy  <= 1'b1;
            state <= S_ADDR;
            if (!req_rw) d_out <= req_wdata;
          end
        end
        S_ADDR: begin
          as    <= 1'b0;
          state <= S_STRB;
          if (l_rw) begin
            uds <= ~l_be[1];
            lds <= ~l_be[0];
          end
        end
        S_STRB: begin
          cnt   <= '0;
          state <= S_WAIT;
          // Writes strobe one cycle after AS so data is settled first.
          if (!l_rw) begin
            uds <= ~l_be[1];
            lds <= ~l_be[0];
          end
        end
        S_WAIT: begin
          if (!dtack_s) begin
            state <= S_SAMPLE;
          end else if (cnt == LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            as    <= 1'b1;
            uds   <= 1'b1;
            lds   <= 1'b1;
            d_oe  <= 1'b0;
            state <= S_RELEASE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SAMPLE: begin
          if (l_rw) rdata <= d_in;
          cnt   <= '0;
          as    <= 1'b1;
          uds   <= 1'b1;
          lds   <= 1'b1;
          d_oe  <= 1'b0;
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (dtack_s) begin
            busy  <= 1'b0;
            done  <= ~err;
            berr  <= err;
            state <= S_IDLE;
          end else if (cnt == LAST) begin
            busy  <= 1'b0;
            berr  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mack_bus_master.sv
// Directed bench for mack_bus_master.
// Responder pulls DTACK low a programmable number of cycles after AS.
module tb_mack_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_rw;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        busy, done, berr;
  logic [15:0] rdata;
  logic [22:0] addr;
  logic [15:0] d_out;
  logic        d_oe;
  logic [15:0] d_in;
  logic        as, uds, lds, rw;
  logic        dtack;

  logic        dt_en;
  int          dt_dly;
  int          as_cnt;

  int checks = 0;
  int errors = 0;

  logic        s_as[0:31], s_uds[0:31], s_lds[0:31], s_rw[0:31];
  logic        s_doe[0:31], s_done[0:31], s_berr[0:31], s_busy[0:31];
  logic [15:0] s_dout[0:31], s_rdata[0:31];
  logic [22:0] s_addr[0:31];

  mack_bus_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .busy(busy), .done(done), .berr(berr), .rdata(rdata),
    .addr(addr), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
    .as(as), .uds(uds), .lds(lds), .rw(rw), .dtack(dtack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) as_cnt <= as ? 0 : as_cnt + 1;

  assign dtack = as | ~dt_en | (as_cnt < dt_dly);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(int k);
    s_as[k]    = as;
    s_uds[k]   = uds;
    s_lds[k]   = lds;
    s_rw[k]    = rw;
    s_doe[k]   = d_oe;
    s_done[k]  = done;
    s_berr[k]  = berr;
    s_busy[k]  = busy;
    s_dout[k]  = d_out;
    s_rdata[k] = rdata;
    s_addr[k]  = addr;
  endtask

  // Index k holds outputs sampled 1 time unit after edge Ek.
  task automatic run(int n, bit hold);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    sample(0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      sample(k);
    end
  endtask

  function automatic int count_done(int n);
    int c = 0;
    for (int k = 0; k <= n; k++) c += int'(s_done[k]);
    return c;
  endfunction

  function automatic int count_berr(int n);
    int c = 0;
    for (int k = 0; k <= n; k++) c += int'(s_berr[k]);
    return c;
  endfunction

  initial begin
    int nd;
    rst = 1'b1; req = 1'b0; req_rw = 1'b1; req_addr = '0;
    req_wdata = '0; req_be = 2'b11; d_in = '0;
    dt_en = 1'b1; dt_dly = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_as", as, 1);
    chk("rst_strb", {uds, lds}, 2'b11);
    chk("rst_rw", rw, 1);
    chk("rst_busy", {busy, done, berr, d_oe}, 4'b0);
    chk("rst_addr", addr, 0);
    chk("rst_rdata", rdata, 0);

    // Zero-wait read
    req = 1'b1; req_rw = 1'b1; req_addr = 23'h1C0000;
    req_be = 2'b11; d_in = 16'hBEEF;
    run(12, 1'b0);
    chk("rd_busy0", s_busy[0], 1);
    chk("rd_as_e0", s_as[0], 1);
    chk("rd_as_e1", s_as[1], 0);
    chk("rd_as_e4", s_as[4], 0);
    chk("rd_as_e5", s_as[5], 1);
    chk("rd_strb_e1", {s_uds[1], s_lds[1]}, 2'b00);
    chk("rd_rw", s_rw[3], 1);
    chk("rd_addr", s_addr[1], 23'h1C0000);
    chk("rd_rdata_e4", s_rdata[4], 0);
    chk("rd_rdata_e5", s_rdata[5], 16'hBEEF);
    chk("rd_done_e7", s_done[7], 0);
    chk("rd_done_e8", s_done[8], 1);
    chk("rd_busy_e8", s_busy[8], 0);
    chk("rd_busy_e7", s_busy[7], 1);
    chk("rd_ndone", count_done(12), 1);
    chk("rd_addr_idle", s_addr[11], 23'h1C0000);

    // Upper-byte write
    req = 1'b1; req_rw = 1'b0; req_addr = 23'h000123;
    req_be = 2'b10; req_wdata = 16'h1234;
    run(12, 1'b0);
    chk("wr_doe_e1", s_doe[1], 1);
    chk("wr_dout_e1", s_dout[1], 16'h1234);
    chk("wr_doe_e4", s_doe[4], 1);
    chk("wr_dout_e4", s_dout[4], 16'h1234);
    chk("wr_doe_e5", s_doe[5], 0);
    chk("wr_uds_e1", s_uds[1], 1);
    chk("wr_uds_e2", s_uds[2], 0);
    chk("wr_lds_e3", s_lds[3], 1);
    chk("wr_uds_e5", s_uds[5], 1);
    chk("wr_rw", s_rw[2], 0);
    chk("wr_done_e8", s_done[8], 1);
    chk("wr_rdata", s_rdata[10], 16'hBEEF);

    // DTACK five cycles late
    dt_dly = 5;
    req = 1'b1; req_rw = 1'b1; req_be = 2'b11; d_in = 16'h5A5A;
    run(16, 1'b0);
    chk("dly_rdata_e9", s_rdata[9], 16'hBEEF);
    chk("dly_rdata_e10", s_rdata[10], 16'h5A5A);
    chk("dly_done_e12", s_done[12], 0);
    chk("dly_done_e13", s_done[13], 1);
    chk("dly_ndone", count_done(16), 1);
    dt_dly = 0;

    // No DTACK: timeout into BERR
    dt_en = 1'b0;
    req = 1'b1; req_rw = 1'b1; d_in = 16'h1111;
    run(14, 1'b0);
    chk("to_as_e9", s_as[9], 0);
    chk("to_as_e10", s_as[10], 1);
    chk("to_berr_e10", s_berr[10], 0);
    chk("to_berr_e11", s_berr[11], 1);
    chk("to_busy_e11", s_busy[11], 0);
    chk("to_nberr", count_berr(14), 1);
    chk("to_ndone", count_done(14), 0);
    chk("to_rdata", s_rdata[12], 16'h5A5A);
    chk("to_strb", {s_as[12], s_uds[12], s_lds[12]}, 3'b111);
    dt_en = 1'b1;

    // Reset while in WAIT
    req = 1'b1; req_rw = 1'b1; d_in = 16'h7777;
    run(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mr_strb", {as, uds, lds}, 3'b111);
    chk("mr_hs", {busy, done, berr, d_oe}, 4'b0);
    chk("mr_rdata", rdata, 0);
    chk("mr_addr", addr, 0);
    run(12, 1'b0);
    chk("mr_ndone", count_done(12) + count_berr(12), 0);
    req = 1'b1;
    run(12, 1'b0);
    chk("mr_next_done", s_done[8], 1);
    chk("mr_next_rdata", s_rdata[8], 16'h7777);

    // REQ held high, BE = 00 -> back-to-back, both strobes
    req = 1'b1; req_rw = 1'b1; req_be = 2'b00; d_in = 16'h2222;
    run(20, 1'b1);
    chk("b2b_strb", {s_uds[3], s_lds[3]}, 2'b00);
    chk("b2b_done1", s_done[8], 1);
    chk("b2b_busy9", s_busy[9], 1);
    chk("b2b_done2", s_done[17], 1);
    chk("b2b_ndone", count_done(20), 2);
    req = 1'b0;
    repeat (14) @(posedge clk);

    // REQ toggling while busy is ignored
    req = 1'b1; req_rw = 1'b0; req_be = 2'b01; req_wdata = 16'hABCD;
    @(posedge clk); #1 req = 1'b0;
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("tg_dout", d_out, 16'hABCD);
      if (k == 2) chk("tg_strb", {uds, lds}, 2'b10);
      if (k == 3 || k == 5) req = 1'b1;
      if (k == 4 || k == 6) req = 1'b0;
      nd += int'(done);
    end
    chk("tg_ndone", nd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
